// File: rtl/hpdcache_perf_pkg.sv
// Shared definitions for the HPDcache performance counter block: event
// numbering, default counter width and the read-index width helper.
package hpdcache_perf_pkg;

    // Bit position of each event inside evt_i.
    typedef enum logic [2:0] {
        WRITE_MISS = 3'd0,
        READ_MISS  = 3'd1,
        UNCACHED   = 3'd2,
        CMO        = 3'd3,
        WRITE      = 3'd4,
        READ       = 3'd5,
        GRANTED    = 3'd6,
        ON_HOLD    = 3'd7
    } hpdcache_perf_evt_e;

    localparam int HPDCACHE_PERF_NB_EVT = 8;
    localparam int HPDCACHE_PERF_CNT_W  = 32;

    // The read index carries one spare bit above what is needed to address
    // NB_EVT counters, so that an out-of-range index can be expressed on the
    // port and reported as an error instead of aliasing onto a real counter.
    function automatic int hpdcache_perf_idx_w(input int nb_evt);
        return $clog2(nb_evt) + 1;
    endfunction

endpackage

// File: rtl/hpdcache_perf_cnt_unit.sv
// One event counter with sticky overflow flag.
//   - inc_i      : count one event this cycle
//   - clr_i      : local clear (clear-on-read); an event in the same cycle
//                  is kept, so the counter lands on 1
//   - clr_all_i  : global clear; wins over everything, the event is dropped
// With SATURATE=0 the counter wraps to 0 and sets ovf; with SATURATE=1 it
// holds all-ones and sets ovf on the first increment attempted there.
module hpdcache_perf_cnt_unit
    import hpdcache_perf_pkg::*;
#(
    parameter int CNT_W    = HPDCACHE_PERF_CNT_W,
    parameter bit SATURATE = 1'b0
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             clr_i,
    input  logic             clr_all_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             ovf_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             at_max;

    assign at_max = (cnt_q == CNT_MAX);

    // Next counter/overflow value: global clear, then local clear, then count.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clr_all_i) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (clr_i) begin
            cnt_d = inc_i ? CNT_ONE : '0;
            ovf_d = 1'b0;
        end else if (inc_i) begin
            if (at_max) begin
                cnt_d = SATURATE ? CNT_MAX : '0;
                ovf_d = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end
    end

    // Counter and overflow state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt_o = cnt_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/hpdcache_perf_cnt.sv
// HPDcache performance counter bank.
// NB_EVT event counters with a valid/ready read port and a one-entry
// response buffer.
//
// Handshake: a request is accepted on a rising edge where
// req_valid_i && req_ready_o; a response is delivered on a rising edge where
// rsp_valid_o && rsp_ready_i. req_ready_o = !rsp_valid_o || rsp_ready_i, so a
// new request may be accepted in the same cycle the pending response leaves
// (one read per cycle). While rsp_valid_o && !rsp_ready_i the response fields
// do not change. The response shows the counter value as it stood before the
// edge that accepted the request.
module hpdcache_perf_cnt
    import hpdcache_perf_pkg::*;
#(
    parameter int NB_EVT   = HPDCACHE_PERF_NB_EVT,
    parameter int CNT_W    = HPDCACHE_PERF_CNT_W,
    parameter bit SATURATE = 1'b0,
    localparam int IDX_W   = hpdcache_perf_idx_w(NB_EVT)
)(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [NB_EVT-1:0] evt_i,
    input  logic              cnt_en_i,
    input  logic              clr_all_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic [IDX_W-1:0]  req_idx_i,
    input  logic              req_clr_i,
    output logic              rsp_valid_o,
    input  logic              rsp_ready_i,
    output logic [CNT_W-1:0]  rsp_data_o,
    output logic              rsp_ovf_o,
    output logic              rsp_err_o
);

    logic [NB_EVT-1:0][CNT_W-1:0] cnt;
    logic [NB_EVT-1:0]            ovf;
    logic [NB_EVT-1:0]            inc;
    logic [NB_EVT-1:0]            clr_sel;

    logic             req_fire;
    logic             idx_ok;
    logic [CNT_W-1:0] sel_cnt;
    logic             sel_ovf;

    logic             rsp_valid_q;
    logic [CNT_W-1:0] rsp_data_q;
    logic             rsp_ovf_q;
    logic             rsp_err_q;

    assign req_ready_o = !rsp_valid_q || rsp_ready_i;
    assign req_fire    = req_valid_i && req_ready_o;
    assign idx_ok      = (int'(req_idx_i) < NB_EVT);
    assign inc         = evt_i & {NB_EVT{cnt_en_i}};

    // Select the addressed counter and raise its clear-on-read strobe; an
    // out-of-range index matches no counter, so it reads zero and clears nothing.
    always_comb begin
        sel_cnt = '0;
        sel_ovf = 1'b0;
        clr_sel = '0;
        for (int k = 0; k < NB_EVT; k++) begin
            if (req_idx_i == IDX_W'(k)) begin
                sel_cnt    = cnt[k];
                sel_ovf    = ovf[k];
                clr_sel[k] = req_fire && req_clr_i;
            end
        end
    end

    for (genvar k = 0; k < NB_EVT; k++) begin : g_unit
        hpdcache_perf_cnt_unit #(
            .CNT_W    (CNT_W),
            .SATURATE (SATURATE)
        ) u_unit (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .inc_i     (inc[k]),
            .clr_i     (clr_sel[k]),
            .clr_all_i (clr_all_i),
            .cnt_o     (cnt[k]),
            .ovf_o     (ovf[k])
        );
    end

    // One-entry response buffer: load on acceptance, drain on rsp_ready_i,
    // otherwise hold every field steady.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else if (req_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= idx_ok ? sel_cnt : '0;
            rsp_ovf_q   <= idx_ok && sel_ovf;
            rsp_err_q   <= !idx_ok;
        end else if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
        end
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_ovf_o   = rsp_ovf_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_hpdcache_perf_cnt.sv
// Bench for hpdcache_perf_cnt. Three instances share one stimulus stream:
// main (CNT_W=32, wrap), wrp (CNT_W=8, wrap) and sat (CNT_W=8, saturate).
module tb_hpdcache_perf_cnt;

    logic       clk;
    logic       rst;
    logic [7:0] evt;
    logic       cnt_en;
    logic       clr_all;
    logic       req_valid;
    logic [3:0] req_idx;
    logic       req_clr;
    logic       rsp_ready;

    logic        m_req_ready, m_rsp_valid, m_rsp_ovf, m_rsp_err;
    logic [31:0] m_rsp_data;
    logic        w_req_ready, w_rsp_valid, w_rsp_ovf, w_rsp_err;
    logic [7:0]  w_rsp_data;
    logic        s_req_ready, s_rsp_valid, s_rsp_ovf, s_rsp_err;
    logic [7:0]  s_rsp_data;

    int tests;
    int failed;

    hpdcache_perf_cnt #(.NB_EVT(8), .CNT_W(32), .SATURATE(1'b0)) u_dut_main (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .cnt_en_i(cnt_en), .clr_all_i(clr_all),
        .req_valid_i(req_valid), .req_ready_o(m_req_ready), .req_idx_i(req_idx),
        .req_clr_i(req_clr), .rsp_valid_o(m_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(m_rsp_data), .rsp_ovf_o(m_rsp_ovf), .rsp_err_o(m_rsp_err)
    );

    hpdcache_perf_cnt #(.NB_EVT(8), .CNT_W(8), .SATURATE(1'b0)) u_dut_wrp (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .cnt_en_i(cnt_en), .clr_all_i(clr_all),
        .req_valid_i(req_valid), .req_ready_o(w_req_ready), .req_idx_i(req_idx),
        .req_clr_i(req_clr), .rsp_valid_o(w_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(w_rsp_data), .rsp_ovf_o(w_rsp_ovf), .rsp_err_o(w_rsp_err)
    );

    hpdcache_perf_cnt #(.NB_EVT(8), .CNT_W(8), .SATURATE(1'b1)) u_dut_sat (
        .clk_i(clk), .rst_i(rst), .evt_i(evt), .cnt_en_i(cnt_en), .clr_all_i(clr_all),
        .req_valid_i(req_valid), .req_ready_o(s_req_ready), .req_idx_i(req_idx),
        .req_clr_i(req_clr), .rsp_valid_o(s_rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_data_o(s_rsp_data), .rsp_ovf_o(s_rsp_ovf), .rsp_err_o(s_rsp_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks (start and end at posedge+1) ----------------
    task automatic pulse(input logic [7:0] v, input int n);
        cnt_en = 1'b1;
        evt    = v;
        repeat (n) @(posedge clk);
        #1;
        evt = '0;
    endtask

    task automatic do_read(input logic [3:0] idx, input logic clr, input logic [7:0] ev);
        req_valid = 1'b1;
        req_idx   = idx;
        req_clr   = clr;
        rsp_ready = 1'b1;
        evt       = ev;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_clr   = 1'b0;
        evt       = '0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        if ({m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data} !== 35'd0) begin
            $display("FAIL reset_main: got v=%0b e=%0b o=%0b d=%0d, expected all 0",
                     m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data);
            failed++;
        end
        tests++;
        if ({w_rsp_valid, w_rsp_err, w_rsp_ovf, w_rsp_data, s_rsp_valid, s_rsp_err, s_rsp_ovf, s_rsp_data} !== 22'd0) begin
            $display("FAIL reset_w8: got wrp d=%0d sat d=%0d flags %0b%0b%0b/%0b%0b%0b, expected all 0",
                     w_rsp_data, s_rsp_data, w_rsp_valid, w_rsp_err, w_rsp_ovf, s_rsp_valid, s_rsp_err, s_rsp_ovf);
            failed++;
        end
        tests++;
        rst = 1'b0;
        @(posedge clk);
        #1;
        if ({m_req_ready, w_req_ready, s_req_ready} !== 3'b111) begin
            $display("FAIL reset_ready: got %b, expected 111", {m_req_ready, w_req_ready, s_req_ready});
            failed++;
        end
        tests++;
    endtask

    task automatic test_basic();
        pulse(8'h02, 5);
        do_read(4'd1, 1'b0, 8'h00);
        if ({m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data} !== {3'b100, 32'd5}) begin
            $display("FAIL basic_main: got v=%0b e=%0b o=%0b d=%0d, expected v=1 e=0 o=0 d=5",
                     m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data);
            failed++;
        end
        tests++;
        if ({w_rsp_ovf, w_rsp_data, s_rsp_ovf, s_rsp_data} !== {1'b0, 8'd5, 1'b0, 8'd5}) begin
            $display("FAIL basic_w8: got wrp d=%0d o=%0b sat d=%0d o=%0b, expected 5/0 5/0",
                     w_rsp_data, w_rsp_ovf, s_rsp_data, s_rsp_ovf);
            failed++;
        end
        tests++;
    endtask

    task automatic test_count_enable();
        cnt_en = 1'b0;
        evt    = 8'h02;
        repeat (3) @(posedge clk);
        #1;
        evt    = '0;
        cnt_en = 1'b1;
        do_read(4'd1, 1'b0, 8'h00);
        if (m_rsp_data !== 32'd5) begin
            $display("FAIL cnt_en_off: got d=%0d, expected 5", m_rsp_data);
            failed++;
        end
        tests++;
        do_read(4'd2, 1'b0, 8'h00);
        if ({m_rsp_valid, m_rsp_ovf, m_rsp_data} !== {2'b10, 32'd0}) begin
            $display("FAIL idle_counter: got v=%0b o=%0b d=%0d, expected v=1 o=0 d=0",
                     m_rsp_valid, m_rsp_ovf, m_rsp_data);
            failed++;
        end
        tests++;
    endtask

    task automatic test_wrap();
        pulse(8'h01, 257);
        do_read(4'd0, 1'b1, 8'h00);
        if ({w_rsp_valid, w_rsp_ovf, w_rsp_data} !== {2'b11, 8'd1}) begin
            $display("FAIL wrap_w8: got v=%0b o=%0b d=%0d, expected v=1 o=1 d=1",
                     w_rsp_valid, w_rsp_ovf, w_rsp_data);
            failed++;
        end
        tests++;
        if ({m_rsp_ovf, m_rsp_data, s_rsp_ovf, s_rsp_data} !== {1'b0, 32'd257, 1'b1, 8'd255}) begin
            $display("FAIL wrap_others: got main d=%0d o=%0b sat d=%0d o=%0b, expected 257/0 255/1",
                     m_rsp_data, m_rsp_ovf, s_rsp_data, s_rsp_ovf);
            failed++;
        end
        tests++;
        do_read(4'd0, 1'b0, 8'h00);
        if ({m_rsp_ovf, m_rsp_data, w_rsp_ovf, w_rsp_data, s_rsp_ovf, s_rsp_data} !== 51'd0) begin
            $display("FAIL wrap_after_clr: got main %0d/%0b wrp %0d/%0b sat %0d/%0b, expected all 0",
                     m_rsp_data, m_rsp_ovf, w_rsp_data, w_rsp_ovf, s_rsp_data, s_rsp_ovf);
            failed++;
        end
        tests++;
    endtask

    task automatic test_saturate();
        pulse(8'h01, 255);
        do_read(4'd0, 1'b0, 8'h00);
        if ({w_rsp_ovf, w_rsp_data, s_rsp_ovf, s_rsp_data} !== {1'b0, 8'd255, 1'b0, 8'd255}) begin
            $display("FAIL sat_at_max: got wrp %0d/%0b sat %0d/%0b, expected 255/0 255/0",
                     w_rsp_data, w_rsp_ovf, s_rsp_data, s_rsp_ovf);
            failed++;
        end
        tests++;
        pulse(8'h01, 45);
        do_read(4'd0, 1'b1, 8'h00);
        if ({s_rsp_valid, s_rsp_ovf, s_rsp_data} !== {2'b11, 8'd255}) begin
            $display("FAIL sat_hold: got v=%0b o=%0b d=%0d, expected v=1 o=1 d=255",
                     s_rsp_valid, s_rsp_ovf, s_rsp_data);
            failed++;
        end
        tests++;
        if ({m_rsp_ovf, m_rsp_data, w_rsp_ovf, w_rsp_data} !== {1'b0, 32'd300, 1'b1, 8'd44}) begin
            $display("FAIL sat_others: got main %0d/%0b wrp %0d/%0b, expected 300/0 44/1",
                     m_rsp_data, m_rsp_ovf, w_rsp_data, w_rsp_ovf);
            failed++;
        end
        tests++;
    endtask

    task automatic test_clr_race();
        pulse(8'h08, 10);
        do_read(4'd3, 1'b1, 8'h08);
        if ({m_rsp_data, w_rsp_data, s_rsp_data} !== {32'd10, 8'd10, 8'd10}) begin
            $display("FAIL clr_race_rsp: got %0d/%0d/%0d, expected 10/10/10",
                     m_rsp_data, w_rsp_data, s_rsp_data);
            failed++;
        end
        tests++;
        do_read(4'd3, 1'b0, 8'h00);
        if ({m_rsp_ovf, m_rsp_data, w_rsp_data, s_rsp_data} !== {1'b0, 32'd1, 8'd1, 8'd1}) begin
            $display("FAIL clr_race_next: got %0d/%0d/%0d o=%0b, expected 1/1/1 o=0",
                     m_rsp_data, w_rsp_data, s_rsp_data, m_rsp_ovf);
            failed++;
        end
        tests++;
    endtask

    task automatic test_backpressure();
        pulse(8'h10, 2);
        req_valid = 1'b1;
        req_idx   = 4'd4;
        req_clr   = 1'b0;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        if ({m_rsp_valid, m_rsp_data} !== {1'b1, 32'd2}) begin
            $display("FAIL bp_first: got v=%0b d=%0d, expected v=1 d=2", m_rsp_valid, m_rsp_data);
            failed++;
        end
        tests++;
        evt = 8'h10;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            if ({m_rsp_valid, m_req_ready, m_rsp_data, w_req_ready} !== {2'b10, 32'd2, 1'b0}) begin
                $display("FAIL bp_stall_%0d: got v=%0b rdy=%0b d=%0d, expected v=1 rdy=0 d=2",
                         i, m_rsp_valid, m_req_ready, m_rsp_data);
                failed++;
            end
            tests++;
        end
        evt       = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if ({m_rsp_valid, m_rsp_data, w_rsp_data} !== {1'b1, 32'd6, 8'd6}) begin
            $display("FAIL bp_release: got v=%0b d=%0d/%0d, expected v=1 d=6/6",
                     m_rsp_valid, m_rsp_data, w_rsp_data);
            failed++;
        end
        tests++;
    endtask

    task automatic test_clr_all();
        // Leave overflow flags set on counter 0 so the global clear must drop them.
        pulse(8'h01, 256);
        clr_all   = 1'b1;
        evt       = 8'hFF;
        cnt_en    = 1'b1;
        req_valid = 1'b1;
        req_idx   = 4'd3;
        req_clr   = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        clr_all   = 1'b0;
        evt       = '0;
        req_valid = 1'b0;
        if ({m_rsp_valid, m_rsp_data} !== {1'b1, 32'd1}) begin
            $display("FAIL clr_all_pre: got v=%0b d=%0d, expected v=1 d=1", m_rsp_valid, m_rsp_data);
            failed++;
        end
        tests++;
        for (int i = 0; i < 8; i++) begin
            do_read(4'(i), 1'b0, 8'h00);
            if ({m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data, w_rsp_ovf, w_rsp_data, s_rsp_ovf, s_rsp_data}
                !== {3'b100, 32'd0, 1'b0, 8'd0, 1'b0, 8'd0}) begin
                $display("FAIL clr_all_idx%0d: got main %0d/%0b wrp %0d/%0b sat %0d/%0b, expected all 0",
                         i, m_rsp_data, m_rsp_ovf, w_rsp_data, w_rsp_ovf, s_rsp_data, s_rsp_ovf);
                failed++;
            end
            tests++;
        end
    endtask

    task automatic test_out_of_range();
        pulse(8'h02, 3);
        do_read(4'd9, 1'b1, 8'h00);
        if ({m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data} !== {3'b110, 32'd0}) begin
            $display("FAIL oor_9: got v=%0b e=%0b o=%0b d=%0d, expected v=1 e=1 o=0 d=0",
                     m_rsp_valid, m_rsp_err, m_rsp_ovf, m_rsp_data);
            failed++;
        end
        tests++;
        do_read(4'd8, 1'b0, 8'h00);
        if ({w_rsp_err, w_rsp_data, s_rsp_err, s_rsp_data} !== {1'b1, 8'd0, 1'b1, 8'd0}) begin
            $display("FAIL oor_8: got wrp e=%0b d=%0d sat e=%0b d=%0d, expected e=1 d=0",
                     w_rsp_err, w_rsp_data, s_rsp_err, s_rsp_data);
            failed++;
        end
        tests++;
        do_read(4'd1, 1'b0, 8'h00);
        if ({m_rsp_err, m_rsp_data, w_rsp_data} !== {1'b0, 32'd3, 8'd3}) begin
            $display("FAIL oor_no_side_effect: got e=%0b d=%0d/%0d, expected e=0 d=3/3",
                     m_rsp_err, m_rsp_data, w_rsp_data);
            failed++;
        end
        tests++;
    endtask

    task automatic test_reset_mid();
        pulse(8'h04, 2);
        req_valid = 1'b1;
        req_idx   = 4'd2;
        rsp_ready = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        if ({m_rsp_valid, m_rsp_data} !== {1'b1, 32'd2}) begin
            $display("FAIL mid_pending: got v=%0b d=%0d, expected v=1 d=2", m_rsp_valid, m_rsp_data);
            failed++;
        end
        tests++;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        if ({m_rsp_valid, m_req_ready, m_rsp_data} !== {2'b01, 32'd0}) begin
            $display("FAIL mid_reset: got v=%0b rdy=%0b d=%0d, expected v=0 rdy=1 d=0",
                     m_rsp_valid, m_req_ready, m_rsp_data);
            failed++;
        end
        tests++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        if ({m_rsp_valid, w_rsp_valid, s_rsp_valid} !== 3'b000) begin
            $display("FAIL mid_no_rsp: got %b, expected 000", {m_rsp_valid, w_rsp_valid, s_rsp_valid});
            failed++;
        end
        tests++;
        do_read(4'd2, 1'b0, 8'h00);
        if ({m_rsp_valid, m_rsp_data, w_rsp_data} !== {1'b1, 32'd0, 8'd0}) begin
            $display("FAIL mid_cnt_cleared: got v=%0b d=%0d/%0d, expected v=1 d=0/0",
                     m_rsp_valid, m_rsp_data, w_rsp_data);
            failed++;
        end
        tests++;
    endtask

    // Sequencer
    initial begin
        tests     = 0;
        failed    = 0;
        rst       = 1'b1;
        evt       = '0;
        cnt_en    = 1'b0;
        clr_all   = 1'b0;
        req_valid = 1'b0;
        req_idx   = '0;
        req_clr   = 1'b0;
        rsp_ready = 1'b0;

        test_reset();
        test_basic();
        test_count_enable();
        test_wrap();
        test_saturate();
        test_clr_race();
        test_backpressure();
        test_clr_all();
        test_out_of_range();
        test_reset_mid();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
